cache_controller: RTL and testbench
===================================

# cache_controller

Sequencer for the direct-mapped, write-through, no-write-allocate cache. Accepts one CPU load/store at a time, drives the cache's lookup/update/write port, performs whole-line fills from main memory on read misses, and forwards every store to memory. Sits between the CPU memory stage, the cache datapath and the memory bus. Keeps saturating hit and miss counters for profiling.

## Interface
- LOG_NUM_LINES, 2, log2 of the number of cache lines (must match the cache)
- LOG_NUM_BLOCKS, 1, log2 of the number of words per line (must match the cache)
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 8, word address width
- CNT_WIDTH, 16, width of the hit and miss counters
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_ready  out  1  controller can accept a request (high only in IDLE)
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  load data, valid with cpu_done and held until the next cpu_done
- cache_update  out  1  fill write to the cache (sets tag and valid)
- cache_write_en  out  1  store-hit write to the cache
- cache_addr  out  ADDR_WIDTH  cache address
- cache_wdata  out  DATA_WIDTH  cache write data
- cache_hit  in  1  combinational hit from the cache
- cache_rdata  in  DATA_WIDTH  combinational read data from the cache
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completion; meaningful only while mem_req is high
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- hit_count, miss_count  out  CNT_WIDTH  saturating lookup counters

## Operation
- States: IDLE, COMPARE, FILL, WRITE_MEM.
- IDLE: cpu_ready = 1. When cpu_req is high, latch cpu_addr, cpu_we and cpu_wdata into req_addr, req_we and req_wdata, then go to COMPARE.
- COMPARE: cache_addr = req_addr.
  - Load hit: set cpu_rdata to cache_rdata, pulse cpu_done, increment hit_count, go to IDLE.
  - Load miss: clear fill_cnt, increment miss_count, go to FILL.
  - Store: assert cache_write_en with cache_wdata = req_wdata. The cache ignores this on a miss, so no allocation occurs. Count a hit or miss from cache_hit, then go to WRITE_MEM.
  - The post-fill re-lookup does not touch the counters (fill_done flag).
- FILL: mem_req = 1, mem_we = 0, mem_addr = {req_addr tag and index, fill_cnt}.
  - On each cycle with mem_ack: cache_update = 1, cache_addr = mem_addr, cache_wdata = mem_rdata.
  - After an acked beat with fill_cnt = NUM_BLOCKS-1, set fill_done and return to COMPARE. The re-lookup is guaranteed to hit and completes the load. Otherwise fill_cnt increments.
- WRITE_MEM: mem_req = 1, mem_we = 1, mem_addr = req_addr, mem_wdata = req_wdata. On mem_ack, pulse cpu_done and go to IDLE. cpu_rdata is unchanged.
- Counters saturate at all-ones and do not wrap.
- cache_update and cache_write_en are never high in the same cycle.

## Timing
- Reset values:
  - state = IDLE, so cpu_ready = 1.
  - cpu_done, cpu_rdata, hit_count, miss_count, fill_cnt and fill_done are 0.
  - All mem_* and cache_* strobes are 0.
- Reset asserted mid-operation aborts immediately and asynchronously. mem_req drops without waiting for mem_ack, and a partially filled line stays partially valid.
- mem_req, mem_we, mem_addr, mem_wdata and the cache_* strobes decode combinationally from registered state only. mem_* outputs stay stable until mem_ack.
- mem_ack may arrive in the same cycle mem_req rises (zero-wait memory).
- cpu_done is registered and appears in the first IDLE cycle. A new request may be accepted in that same cycle, so back-to-back requests are legal.
- Latency, counted from the accept edge to the cpu_done cycle:
  - Load hit: 2 cycles.
  - Store: 2 cycles plus memory wait.
  - Load miss: 3 cycles plus NUM_BLOCKS acked beats.
- cpu_req while not in IDLE is ignored.

## Structure
- Shared package holds:
  - The state enum.
  - NUM_TAG_BITS, NUM_LINES and NUM_BLOCKS, derived exactly as the cache derives them.
  - Address-field slice helpers (tag, index, offset).
- Single module with no sub-module. The two saturating counters may share a local sat_counter sub-module of width CNT_WIDTH.

## Test plan
Default parameters; memory models are zero-wait except where stated.

- Reset then idle: cpu_ready = 1, all strobes 0, counters 0.
- Load 0x14 on a cold cache:
  - miss_count = 1.
  - mem reads to 0x14 then 0x15, each with cache_update.
  - cpu_done with memory value M[0x14], 5 cycles after accept.
  - hit_count stays 0.
- Load 0x15 after the previous test: hit; cpu_done 2 cycles after accept with M[0x15]; no mem_req; hit_count = 1.
- Store 0xDEADBEEF to 0x14 (hit): cache_write_en pulse, then a mem write to 0x14 with 3 wait cycles; cpu_done on the cycle after mem_ack. A following load of 0x14 returns 0xDEADBEEF from the cache.
- Store to 0x40 (miss, index 0 invalid): cache_write_en pulses but the line stays invalid; a following load of 0x40 misses and fills 0x40 and 0x41.
- Async rst asserted during FILL beat 1 (memory waits 5 cycles): mem_req drops the same cycle; after release, cpu_ready = 1 and a load 0x14 re-fills correctly.
- Counter saturation with CNT_WIDTH = 2: four load hits leave hit_count = 3.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared types and address-field helpers for the cache controller.
// Geometry helpers mirror the cache datapath's derivation of line/block/tag sizes.
package cache_controller_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StFill,
        StWriteMem
    } state_t;

    function automatic int unsigned num_lines(input int unsigned log_num_lines);
        return 32'd1 << log_num_lines;
    endfunction

    function automatic int unsigned num_blocks(input int unsigned log_num_blocks);
        return 32'd1 << log_num_blocks;
    endfunction

    function automatic int unsigned num_tag_bits(input int unsigned addr_width,
                                                 input int unsigned log_num_lines,
                                                 input int unsigned log_num_blocks);
        return addr_width - log_num_lines - log_num_blocks;
    endfunction

    function automatic int unsigned addr_tag(input int unsigned addr,
                                             input int unsigned log_num_lines,
                                             input int unsigned log_num_blocks);
        return addr >> (log_num_lines + log_num_blocks);
    endfunction

    function automatic int unsigned addr_index(input int unsigned addr,
                                               input int unsigned log_num_lines,
                                               input int unsigned log_num_blocks);
        return (addr >> log_num_blocks) & ((32'd1 << log_num_lines) - 32'd1);
    endfunction

    function automatic int unsigned addr_offset(input int unsigned addr,
                                                input int unsigned log_num_blocks);
        return addr & ((32'd1 << log_num_blocks) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_controller.sv
// Sequencer for a direct-mapped, write-through, no-write-allocate cache:
// one CPU access at a time, whole-line fills on load misses, every store forwarded to memory.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int unsigned LOG_NUM_LINES  = 2,
    parameter int unsigned LOG_NUM_BLOCKS = 1,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cache_update,
    output logic                  cache_write_en,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int unsigned NUM_BLOCKS   = num_blocks(LOG_NUM_BLOCKS);
    localparam int unsigned NUM_TAG_BITS = num_tag_bits(ADDR_WIDTH, LOG_NUM_LINES, LOG_NUM_BLOCKS);

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      req_we;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [LOG_NUM_BLOCKS-1:0] fill_cnt;
    logic                      fill_done;

    logic [NUM_TAG_BITS-1:0]   req_tag;
    logic [LOG_NUM_LINES-1:0]  req_index;
    logic [ADDR_WIDTH-1:0]     fill_addr;
    logic                      fill_last;

    assign req_tag   = NUM_TAG_BITS'(addr_tag(32'(req_addr), LOG_NUM_LINES, LOG_NUM_BLOCKS));
    assign req_index = LOG_NUM_LINES'(addr_index(32'(req_addr), LOG_NUM_LINES, LOG_NUM_BLOCKS));
    assign fill_addr = {req_tag, req_index, fill_cnt};
    assign fill_last = (fill_cnt == LOG_NUM_BLOCKS'(NUM_BLOCKS - 1));

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            fill_cnt   <= '0;
            fill_done  <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        state     <= StCompare;
                    end
                end
                StCompare: begin
                    fill_done <= 1'b0;
                    if (req_we) begin
                        // The cache drops the write itself on a miss; only the profile differs.
                        if (cache_hit) hit_count <= sat_inc(hit_count);
                        else           miss_count <= sat_inc(miss_count);
                        state <= StWriteMem;
                    end else if (cache_hit) begin
                        cpu_rdata <= cache_rdata;
                        cpu_done  <= 1'b1;
                        if (!fill_done) hit_count <= sat_inc(hit_count);
                        state <= StIdle;
                    end else begin
                        fill_cnt   <= '0;
                        miss_count <= sat_inc(miss_count);
                        state      <= StFill;
                    end
                end
                StFill: begin
                    if (mem_ack) begin
                        if (fill_last) begin
                            fill_done <= 1'b1;
                            state     <= StCompare;
                        end else begin
                            fill_cnt <= fill_cnt + LOG_NUM_BLOCKS'(1);
                        end
                    end
                end
                StWriteMem: begin
                    if (mem_ack) begin
                        cpu_done <= 1'b1;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign cpu_ready = (state == StIdle);

    always_comb begin
        cache_update   = 1'b0;
        cache_write_en = 1'b0;
        cache_addr     = req_addr;
        cache_wdata    = req_wdata;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = req_addr;
        mem_wdata      = req_wdata;
        case (state)
            StCompare: cache_write_en = req_we;
            StFill: begin
                mem_req      = 1'b1;
                mem_addr     = fill_addr;
                cache_update = mem_ack;
                cache_addr   = fill_addr;
                cache_wdata  = mem_rdata;
            end
            StWriteMem: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache and variable-wait memory.
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_done;
    logic [31:0] cpu_rdata;
    logic        cache_update, cache_write_en;
    logic [7:0]  cache_addr;
    logic [31:0] cache_wdata;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] hit_count, miss_count;

    // Second instance with 2-bit counters, run in lockstep on the same inputs.
    logic        s_cpu_ready, s_cpu_done;
    logic [31:0] s_cpu_rdata;
    logic        s_cache_update, s_cache_write_en;
    logic [7:0]  s_cache_addr;
    logic [31:0] s_cache_wdata;
    logic        s_mem_req, s_mem_we;
    logic [7:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [1:0]  s_hit_count, s_miss_count;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cache_update(cache_update), .cache_write_en(cache_write_en),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(s_cpu_ready), .cpu_done(s_cpu_done), .cpu_rdata(s_cpu_rdata),
        .cache_update(s_cache_update), .cache_write_en(s_cache_write_en),
        .cache_addr(s_cache_addr), .cache_wdata(s_cache_wdata),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    // Cache model: 4 lines x 2 words, tag = addr[7:3], index = addr[2:1], offset = addr[0].
    logic        clr;
    logic        c_valid [4];
    logic [4:0]  c_tag   [4];
    logic [31:0] c_data  [4][2];
    logic [1:0]  c_idx;
    logic [31:0] mem     [256];
    int          mem_wait;
    int          wait_cnt = 0;
    int          cyc = 0;

    assign c_idx       = cache_addr[2:1];
    assign cache_hit   = c_valid[c_idx] && (c_tag[c_idx] == cache_addr[7:3]);
    assign cache_rdata = c_data[c_idx][cache_addr[0]];
    assign mem_ack     = mem_req && (wait_cnt >= mem_wait);
    assign mem_rdata   = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) c_valid[i] <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else begin
            if (cache_update) begin
                c_data[c_idx][cache_addr[0]] <= cache_wdata;
                c_tag[c_idx]   <= cache_addr[7:3];
                c_valid[c_idx] <= 1'b1;
            end else if (cache_write_en && cache_hit) begin
                c_data[c_idx][cache_addr[0]] <= cache_wdata;
            end
            if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
        end
    end

    // Bus monitor
    logic [7:0]  rd_log [$];
    int          upd_ok = 0, req_cycles = 0, we_pulses = 0, overlap = 0, lockstep_err = 0;
    int          ack_cyc = 0;
    logic [7:0]  wr_addr = 8'h00;
    logic [31:0] wr_data = 32'h0;

    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            ack_cyc = cyc;
            if (!mem_we) begin
                rd_log.push_back(mem_addr);
                if (cache_update) upd_ok++;
            end else begin
                wr_addr = mem_addr;
                wr_data = mem_wdata;
            end
        end
        if (mem_req) req_cycles++;
        if (cache_write_en) we_pulses++;
        if (cache_update && cache_write_en) overlap++;
        if ({s_cpu_ready, s_cpu_done, s_cpu_rdata, s_cache_update, s_cache_write_en,
             s_cache_addr, s_cache_wdata, s_mem_req, s_mem_we, s_mem_addr, s_mem_wdata} !==
            {cpu_ready, cpu_done, cpu_rdata, cache_update, cache_write_en,
             cache_addr, cache_wdata, mem_req, mem_we, mem_addr, mem_wdata})
            lockstep_err++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    int done_cyc = 0;

    // Issue one request; lat counts edges from the accept edge to the edge raising cpu_done.
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          output int lat);
        @(negedge clk);
        check("ready_before_req", 32'(cpu_ready), 32'h1);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        lat = 1;
        while (!cpu_done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!cpu_done) check("done_timeout", 32'(cpu_done), 32'h1);
        done_cyc = cyc;
    endtask

    int lat, base, base2, n;

    initial begin
        rst = 1'b1; clr = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 32'h0;
        mem_wait = 0;
        repeat (2) @(posedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("rst_ready",   32'(cpu_ready), 32'h1);
        check("rst_done",    32'(cpu_done), 32'h0);
        check("rst_rdata",   cpu_rdata, 32'h0);
        check("rst_strobes", 32'({mem_req, mem_we, cache_update, cache_write_en}), 32'h0);
        check("rst_hits",    32'(hit_count), 32'h0);
        check("rst_misses",  32'(miss_count), 32'h0);
        rst = 1'b0;

        // Cold load miss: two-beat fill then re-lookup
        base = rd_log.size(); base2 = upd_ok;
        do_req(1'b0, 8'h14, 32'h0, lat);
        check("miss_lat",     32'(lat), 32'd5);
        check("miss_rdata",   cpu_rdata, 32'hA500_0014);
        check("miss_cnt",     32'(miss_count), 32'd1);
        check("miss_hitcnt",  32'(hit_count), 32'd0);
        check("fill_beats",   32'(rd_log.size() - base), 32'd2);
        check("fill_addr0",   32'(rd_log[base]), 32'h14);
        check("fill_addr1",   32'(rd_log[base + 1]), 32'h15);
        check("fill_updates", 32'(upd_ok - base2), 32'd2);

        // Load hit on the other word of the filled line
        base = req_cycles;
        do_req(1'b0, 8'h15, 32'h0, lat);
        check("hit_lat",     32'(lat), 32'd2);
        check("hit_rdata",   cpu_rdata, 32'hA500_0015);
        check("hit_no_mem",  32'(req_cycles - base), 32'd0);
        check("hit_cnt",     32'(hit_count), 32'd1);

        // Store hit with a slow memory
        mem_wait = 3;
        base = we_pulses;
        do_req(1'b1, 8'h14, 32'hDEAD_BEEF, lat);
        check("st_we_pulse",  32'(we_pulses - base), 32'd1);
        check("st_mem_addr",  32'(wr_addr), 32'h14);
        check("st_mem_data",  wr_data, 32'hDEAD_BEEF);
        check("st_done_after_ack", 32'(done_cyc), 32'(ack_cyc + 1));
        check("st_hit_cnt",   32'(hit_count), 32'd2);
        check("st_rdata_kept", cpu_rdata, 32'hA500_0015);
        mem_wait = 0;
        do_req(1'b0, 8'h14, 32'h0, lat);
        check("ld_after_st",  cpu_rdata, 32'hDEAD_BEEF);
        check("ld_after_st_lat", 32'(lat), 32'd2);

        // Store miss must not allocate
        base = we_pulses;
        do_req(1'b1, 8'h40, 32'h1234_5678, lat);
        check("stm_we_pulse", 32'(we_pulses - base), 32'd1);
        check("stm_miss_cnt", 32'(miss_count), 32'd2);
        check("stm_hit_cnt",  32'(hit_count), 32'd3);
        base = rd_log.size();
        do_req(1'b0, 8'h40, 32'h0, lat);
        check("stm_ld_lat",   32'(lat), 32'd5);
        check("stm_ld_miss",  32'(miss_count), 32'd3);
        check("stm_fill0",    32'(rd_log[base]), 32'h40);
        check("stm_fill1",    32'(rd_log[base + 1]), 32'h41);
        check("stm_ld_rdata", cpu_rdata, 32'h1234_5678);

        // Asynchronous reset during the second fill beat of a conflicting line
        mem_wait = 5;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h34;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        n = 0;
        while (!(mem_req && mem_addr == 8'h35) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_beat1_addr", 32'(mem_addr), 32'h35);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mem_req_drop", 32'(mem_req), 32'h0);
        check("rst_ready_async",  32'(cpu_ready), 32'h1);
        check("rst_cnt_clear",    32'({hit_count, miss_count}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_wait = 0;
        base = rd_log.size();
        do_req(1'b0, 8'h14, 32'h0, lat);
        check("refill_lat",   32'(lat), 32'd5);
        check("refill_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("refill_addr0", 32'(rd_log[base]), 32'h14);
        check("refill_miss",  32'(miss_count), 32'd1);

        // Four hits saturate the 2-bit counter
        do_req(1'b0, 8'h14, 32'h0, lat);
        do_req(1'b0, 8'h15, 32'h0, lat);
        do_req(1'b0, 8'h14, 32'h0, lat);
        do_req(1'b0, 8'h15, 32'h0, lat);
        check("sat_last_rdata", cpu_rdata, 32'hA500_0015);
        check("wide_hit_cnt",   32'(hit_count), 32'd4);
        check("sat_hit_cnt",    32'(s_hit_count), 32'd3);
        check("sat_miss_cnt",   32'(s_miss_count), 32'd1);

        check("no_strobe_overlap", 32'(overlap), 32'd0);
        check("lockstep",          32'(lockstep_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
